// File: rtl/display_mux_scan.sv
// Time-multiplexed N-digit 7-segment driver: handshake capture, shift-add-3 BCD conversion, double-buffered scan.
// Optional DISPLAY_MUX_LEADING_ZERO_BLANK_EN blanks leading zero digits (units digit and overflow dashes always shown).
module display_mux_scan #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned IN_WIDTH      = 14,
  parameter int unsigned REFRESH_COUNT = 100000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IN_WIDTH-1:0]   value,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  enable,
  output logic [6:0]            segments,
  output logic [NUM_DIGITS-1:0] display_select,
  output logic                  overflow
);

  localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(REFRESH_COUNT);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ITER_W = $clog2(IN_WIDTH + 1);
  localparam logic [6:0]  DASH   = 7'b0000001;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1111110;
      4'd1:    seg_of = 7'b0110000;
      4'd2:    seg_of = 7'b1101101;
      4'd3:    seg_of = 7'b1111001;
      4'd4:    seg_of = 7'b0110011;
      4'd5:    seg_of = 7'b1011011;
      4'd6:    seg_of = 7'b1011111;
      4'd7:    seg_of = 7'b1110000;
      4'd8:    seg_of = 7'b1111111;
      4'd9:    seg_of = 7'b1110011;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d, adj;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                ovf_cap_q, ovf_cap_d;
  logic [BCD_W-1:0]    latch_q, latch_d;
  logic                latch_ovf_q, latch_ovf_d;
  logic [3:0]          nib;
  logic [63:0]         value_ext;

  assign value_ext   = 64'(value);
  assign value_ready = (state_q == S_IDLE);
  assign overflow    = latch_ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      iter_q      <= '0;
      ovf_cap_q   <= 1'b0;
      latch_q     <= '0;
      latch_ovf_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      iter_q      <= iter_d;
      ovf_cap_q   <= ovf_cap_d;
      latch_q     <= latch_d;
      latch_ovf_q <= latch_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    iter_d      = iter_q;
    ovf_cap_d   = ovf_cap_q;
    latch_d     = latch_q;
    latch_ovf_d = latch_ovf_q;
    adj         = bcd_q;
    nib         = '0;
    case (state_q)
      S_IDLE: begin
        if (value_valid) begin
          bin_d     = value;
          bcd_d     = '0;
          iter_d    = '0;
          ovf_cap_d = (value_ext >= OVF_LIMIT);
          state_d   = S_CONVERT;
        end
      end
      S_CONVERT: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          nib = bcd_q[4*i +: 4];
          adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        // Digits that fall off the top of the BCD register are lost; overflow covers them.
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        iter_d = iter_q + ITER_W'(1);
        if (iter_q == ITER_W'(IN_WIDTH - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        latch_d     = bcd_q;
        latch_ovf_d = ovf_cap_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [CNT_W-1:0]      refresh_q;
  logic [IDX_W-1:0]      scan_idx_q;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic [6:0]            seg_n, seg_q;
  logic [NUM_DIGITS-1:0] sel_n, sel_q;
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
  logic                  zero_above;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_q  <= '0;
      scan_idx_q <= '0;
    end else if (enable) begin
      if (refresh_q == CNT_W'(REFRESH_COUNT - 1)) begin
        refresh_q  <= '0;
        scan_idx_q <= (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
      end else begin
        refresh_q <= refresh_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cur_digit = '0;
    blank     = 1'b0;
    sel_n     = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (scan_idx_q == IDX_W'(k)) begin
        cur_digit = latch_q[4*k +: 4];
        sel_n[k]  = 1'b0;
      end
    end
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is blank while everything at and above it is zero.
    zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      zero_above = zero_above & (latch_q[4*(k-1) +: 4] == 4'd0);
      if ((k > 1) && (scan_idx_q == IDX_W'(k - 1))) blank = zero_above;
    end
`endif
    if (latch_ovf_q)  seg_n = DASH;
    else if (blank)   seg_n = '0;
    else              seg_n = seg_of(cur_digit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '0;
      sel_q <= '1;
    end else if (!enable) begin
      seg_q <= '0;
      sel_q <= '1;
    end else begin
      seg_q <= seg_n;
      sel_q <= sel_n;
    end
  end

  assign segments       = seg_q;
  assign display_select = sel_q;

endmodule

// File: tb/tb_display_mux_scan.sv
// Self-checking bench for display_mux_scan: arithmetic reference model checked every cycle plus literal pins.
module tb_display_mux_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned IW = 14;
  localparam int unsigned RC = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [IW-1:0] value;
  logic          value_valid;
  logic          value_ready;
  logic          enable;
  logic [6:0]    segments;
  logic [ND-1:0] display_select;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  display_mux_scan #(.NUM_DIGITS(ND), .IN_WIDTH(IW), .REFRESH_COUNT(RC)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .value_valid(value_valid),
    .value_ready(value_ready), .enable(enable), .segments(segments),
    .display_select(display_select), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  function automatic int unsigned p10(input int unsigned k);
    int unsigned p = 1;
    for (int unsigned i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] expect_seg(input int unsigned disp, input int unsigned k);
    if (disp >= p10(ND)) return 7'b0000001;
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    if (k > 0 && disp < p10(k)) return 7'b0000000;
`endif
    return seg_tab[(disp / p10(k)) % 10];
  endfunction

  // Reference model: scan position from count of enabled edges; latch updates IW+1 edges after accept.
  int unsigned   m_ecount = 0, m_disp = 0, m_pending = 0, m_busy = 0;
  logic [6:0]    exp_seg = '0;
  logic [ND-1:0] exp_sel = '1;
  logic          exp_ovf = 1'b0, exp_ready = 1'b1;
  bit            chk_on = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int unsigned k, nb, nd;
    if (!reset_n) begin
      m_ecount  <= 0;
      m_disp    <= 0;
      m_busy    <= 0;
      exp_seg   <= '0;
      exp_sel   <= '1;
      exp_ovf   <= 1'b0;
      exp_ready <= 1'b1;
    end else begin
      k = (m_ecount / RC) % ND;
      if (enable) begin
        exp_seg  <= expect_seg(m_disp, k);
        exp_sel  <= ~(ND'(1) << k);
        m_ecount <= m_ecount + 1;
      end else begin
        exp_seg <= '0;
        exp_sel <= '1;
      end
      nb = m_busy;
      nd = m_disp;
      if (m_busy == 0) begin
        if (value_valid) begin
          m_pending <= int'(value);
          nb = IW + 1;
        end
      end else begin
        nb = m_busy - 1;
        if (nb == 0) nd = m_pending;
      end
      m_busy    <= nb;
      m_disp    <= nd;
      exp_ovf   <= (nd >= p10(ND));
      exp_ready <= (nb == 0);
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", name, got, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_segments", 16'(segments), 16'(exp_seg));
      chk("model_select", 16'(display_select), 16'(exp_sel));
      chk("model_overflow", 16'(overflow), 16'(exp_ovf));
      chk("model_ready", 16'(value_ready), 16'(exp_ready));
    end
  end

  task automatic wait_sel(input int unsigned k);
    logic [ND-1:0] t;
    int unsigned n;
    t = ~(ND'(1) << k);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (display_select !== t && n < 100);
    if (display_select !== t) chk($sformatf("wait_sel%0d_timeout", k), 16'(display_select), 16'(t));
  endtask

  task automatic wait_ready(output int unsigned n);
    n = 0;
    while (value_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic submit(input int unsigned v, input bit wait_done);
    int unsigned n;
    value = IW'(v);
    value_valid = 1'b1;
    wait_ready(n);
    @(negedge clk);
    value_valid = 1'b0;
    if (wait_done) begin
      wait_ready(n);
      chk($sformatf("busy_cycles_%0d", v), 16'(n), 16'(IW + 1));
    end
  endtask

  initial begin : stim
    int unsigned n;
    reset_n = 1'b0; enable = 1'b0; value_valid = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    chk("rst_segments", 16'(segments), 16'h0);
    chk("rst_select", 16'(display_select), 16'b1111);
    chk("rst_overflow", 16'(overflow), 16'h0);
    chk("rst_ready", 16'(value_ready), 16'h1);
    chk_on = 1;
    reset_n = 1'b1;
    enable = 1'b1;

    wait_sel(1);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (display_select !== 4'b1101) break;
      n++;
    end
    chk("dwell_digit1", 16'(n), 16'(RC));
    chk("zero_latch_d1", 16'(segments), 16'(7'b1111110));

    submit(1234, 1);
    wait_sel(0); chk("v1234_d0", 16'(segments), 16'(7'b0110011));
    wait_sel(1); chk("v1234_d1", 16'(segments), 16'(7'b1111001));
    wait_sel(2); chk("v1234_d2", 16'(segments), 16'(7'b1101101));
    wait_sel(3); chk("v1234_d3", 16'(segments), 16'(7'b0110000));

    submit(10000, 1);
    chk("v10000_ovf", 16'(overflow), 16'h1);
    wait_sel(2); chk("v10000_d2", 16'(segments), 16'(7'b0000001));
    submit(9999, 1);
    chk("v9999_ovf", 16'(overflow), 16'h0);
    wait_sel(3); chk("v9999_d3", 16'(segments), 16'(7'b1110011));

    // value_valid held across a conversion while the source changes value
    value = IW'(1111);
    value_valid = 1'b1;
    wait_ready(n);
    @(negedge clk);
    value = IW'(2222);
    n = 0;
    while (value_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("held_second_accept", 16'(value_ready), 16'h0);
    value_valid = 1'b0;
    wait_ready(n);
    wait_sel(0); chk("v2222_d0", 16'(segments), 16'(7'b1101101));

    submit(4321, 0);
    repeat (5) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_segments", 16'(segments), 16'h0);
    chk("midrst_select", 16'(display_select), 16'b1111);
    chk("midrst_ready", 16'(value_ready), 16'h1);
    chk("midrst_overflow", 16'(overflow), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_sel(3); chk("midrst_zero_d3", 16'(segments), 16'(7'b1111110));

    enable = 1'b0;
    @(negedge clk);
    chk("disabled_select", 16'(display_select), 16'b1111);
    chk("disabled_segments", 16'(segments), 16'h0);
    repeat (7) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);

    submit(7, 1);
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    wait_sel(1); chk("v7_d1", 16'(segments), 16'(7'b0000000));
    wait_sel(0); chk("v7_d0", 16'(segments), 16'(7'b1110000));
    submit(0, 1);
    wait_sel(0); chk("v0_d0", 16'(segments), 16'(7'b1111110));
    wait_sel(2); chk("v0_d2", 16'(segments), 16'(7'b0000000));
`else
    wait_sel(1); chk("v7_d1", 16'(segments), 16'(7'b1111110));
    wait_sel(0); chk("v7_d0", 16'(segments), 16'(7'b1110000));
    submit(0, 1);
    wait_sel(2); chk("v0_d2", 16'(segments), 16'(7'b1111110));
`endif

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_mux_scan.md
Name: display_mux_scan

Overview:
- Parametrised N-digit, time-multiplexed 7-segment driver for unsigned binary results such as the adder sum.
- Accepts a new value through a valid/ready handshake and converts it to BCD in a sequential shift-add-3 FSM.
- Double-buffers the digits so the display never tears, and scans NUM_DIGITS common-anode digits at a programmable refresh period.
- Sits between the arithmetic datapath and the board's display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 1..8.
- IN_WIDTH, 14: width of the binary input value.
- REFRESH_COUNT, 100000: clock cycles each digit stays selected; must be ≥2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- value  input  IN_WIDTH  unsigned binary value to display
- value_valid  input  1  value is presented for capture
- value_ready  output  1  block can accept a value (FSM in IDLE)
- enable  input  1  display on; low blanks all digits
- segments  output  7  segment drive, active-high, bit6=a … bit0=g
- display_select  output  NUM_DIGITS  active-low one-hot digit enable; bit0 = units digit
- overflow  output  1  displayed value exceeds 10^NUM_DIGITS−1

Behaviour:
- Reset (async assert, sync release):
  - All registers cleared.
  - segments=0, display_select=all ones, overflow=0, value_ready=1.
  - Display latch = all-zero BCD; scan index=0; refresh counter=0.
  - Reset during conversion aborts it; the latch reads zero afterwards.
- Conversion FSM: IDLE → CONVERT → COMMIT → IDLE.
  - IDLE: value_ready=1. On value_valid&&value_ready, capture value into the shift register, clear the BCD register and the iteration counter, go to CONVERT. The overflow flag (value ≥ 10^NUM_DIGITS, parameter-constant compare) is captured in the same cycle.
  - CONVERT: exactly IN_WIDTH cycles. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. After the IN_WIDTH-th shift, go to COMMIT.
  - COMMIT: one cycle. Copy the BCD register and overflow flag into the display latch, then go to IDLE.
  - Latency from accept edge to latch update = IN_WIDTH+1 cycles. value_ready returns high the cycle after COMMIT.
  - value_valid while value_ready=0 is ignored; the source must hold its value. The display shows the old latch throughout conversion.
- BCD width:
  - The BCD register is 4*NUM_DIGITS bits.
  - Digits beyond NUM_DIGITS are discarded when overflow=1.
- Overflow display: when the latched overflow=1, every digit shows a dash (segments=7'b0000001) and the overflow output is 1.
- Scan:
  - The refresh counter counts 0..REFRESH_COUNT−1 and wraps.
  - On wrap, the scan index increments and wraps from NUM_DIGITS−1 to 0, so a non-power-of-2 NUM_DIGITS works.
  - Each digit is selected for exactly REFRESH_COUNT cycles.
- Outputs are registered:
  - segments and display_select reflect the scan index one cycle after it changes.
  - display_select bit k is low when scan index = k.
- enable=0: the refresh counter and scan index hold; display_select=all ones and segments=0 from the next cycle. Conversion continues unaffected.
- Segment codes for 0–9:
  - 1111110, 0110000, 1101101, 1111001, 0110011
  - 1011011, 1011111, 1110000, 1111111, 1110011
  - Any illegal nibble gives 0000000.

Optional Feature:
- Macro: DISPLAY_MUX_LEADING_ZERO_BLANK_EN.
- Defined:
  - Zero digits more significant than the highest nonzero digit show segments=0; their display_select still asserts, so scan timing is unchanged.
  - The units digit is never blanked, so a value of 0 shows a single "0".
  - Overflow dashes are never blanked.
- Undefined: all digits are always shown, including leading zeros.

Test Plan (NUM_DIGITS=4, IN_WIDTH=14, REFRESH_COUNT=4):
- Reset, then enable=1 → display_select cycles 1110,1101,1011,0111, 4 cycles each. segments=1111110 on every digit (zero latch). overflow=0.
- Submit 1234 → value_ready low for 15 cycles; the latch updates 15 cycles after accept. Digits 0..3 show 4,3,2,1 (0110011, 1111001, 1101101, 0110000).
- Submit 10000 → overflow=1 and all digits show 0000001. Then submit 9999 → overflow=0 and all digits show 1110011.
- Hold value_valid through a conversion with a changed value → the second value is accepted only after value_ready re-asserts. The display transitions cleanly from the old value to the new one with no intermediate pattern.
- Assert reset_n low mid-CONVERT → outputs return to reset values immediately and value_ready=1 after release. The display shows 0000. Toggle enable=0 → all digits off and the scan index is frozen.
- With DISPLAY_MUX_LEADING_ZERO_BLANK_EN, submit 7 → digit 0 shows 1110000 and digits 1–3 show 0000000. Submit 0 → only digit 0 shows 1111110.
